// File: rtl/julia_pixel_scheduler.sv
// Raster scheduler feeding Julia engine start points and writing results to the framebuffer.
// Optional palette: define JULIA_COLOR_MAP_EN to map counts to RGB444.
module julia_pixel_scheduler #(
  parameter int          H_RES   = 320,
  parameter int          V_RES   = 240,
  parameter logic [31:0] X_MIN   = 32'hFFFE_0000,
  parameter logic [31:0] Y_MAX   = 32'h0001_8000,
  parameter logic [31:0] STEP    = 32'h0000_0333,
  parameter int          TIMEOUT = 1023,
  parameter int          AW      = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          restart,
  output logic          eng_start,
  output logic [31:0]   eng_x,
  output logic [31:0]   eng_y,
  input  logic          eng_done,
  input  logic [8:0]    eng_iter,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [11:0]   fb_wdata,
  output logic          busy,
  output logic          frame_done
);

  localparam int PXW = $clog2(H_RES + 1);
  localparam int PYW = $clog2(V_RES + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [PXW-1:0]  px, px_n;
  logic [PYW-1:0]  py, py_n;
  logic [31:0]     x_acc, x_n;
  logic [31:0]     y_acc, y_n;
  logic [AW-1:0]   addr_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic            latch;
  logic [8:0]      iter_l;

  function automatic logic [11:0] map_iter(input logic [8:0] it);
    logic [11:0] c;
`ifdef JULIA_COLOR_MAP_EN
    c = 12'h000;
    unique case (it[7:4])
      4'h0: c = 12'h001;
      4'h1: c = 12'h012;
      4'h2: c = 12'h024;
      4'h3: c = 12'h036;
      4'h4: c = 12'h048;
      4'h5: c = 12'h05A;
      4'h6: c = 12'h16C;
      4'h7: c = 12'h28E;
      4'h8: c = 12'h4AF;
      4'h9: c = 12'h6BF;
      4'hA: c = 12'h8CF;
      4'hB: c = 12'hADF;
      4'hC: c = 12'hCEF;
      4'hD: c = 12'hEFF;
      4'hE: c = 12'hFFA;
      4'hF: c = 12'hFF5;
    endcase
    // escape count 256 means the point never escaped: inside the set is black
    if (it[8]) c = 12'h000;
`else
    c = {3'b000, it};
`endif
    return c;
  endfunction

  // Next-state, pixel walk and result capture; restart overrides everything
  always_comb begin
    state_n = state;
    px_n    = px;
    py_n    = py;
    x_n     = x_acc;
    y_n     = y_acc;
    addr_n  = fb_addr;
    tcnt_n  = tcnt;
    latch   = 1'b0;
    iter_l  = eng_iter;
    unique case (state)
      S_IDLE: if (run) state_n = S_ISSUE;
      S_ISSUE: begin
        state_n = S_WAIT;
        tcnt_n  = '0;
      end
      S_WAIT: begin
        if (eng_done) begin
          latch   = 1'b1;
          state_n = S_WRITE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          latch   = 1'b1;
          iter_l  = 9'd256;
          state_n = S_WRITE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_WRITE: state_n = S_NEXT;
      S_NEXT: begin
        if (px == PXW'(H_RES - 1)) begin
          px_n = '0;
          x_n  = X_MIN;
          if (py == PYW'(V_RES - 1)) begin
            py_n    = '0;
            y_n     = Y_MAX;
            addr_n  = '0;
            state_n = S_DONE;
          end else begin
            py_n    = py + PYW'(1);
            y_n     = y_acc - STEP;
            addr_n  = fb_addr + AW'(1);
            state_n = S_ISSUE;
          end
        end else begin
          px_n    = px + PXW'(1);
          x_n     = x_acc + STEP;
          addr_n  = fb_addr + AW'(1);
          state_n = S_ISSUE;
        end
      end
      S_DONE: state_n = run ? S_ISSUE : S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (restart) begin
      state_n = run ? S_ISSUE : S_IDLE;
      px_n    = '0;
      py_n    = '0;
      x_n     = X_MIN;
      y_n     = Y_MAX;
      addr_n  = '0;
      latch   = 1'b0;
    end
  end

  // State, counters, engine operands and write data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      px       <= '0;
      py       <= '0;
      x_acc    <= X_MIN;
      y_acc    <= Y_MAX;
      fb_addr  <= '0;
      tcnt     <= '0;
      fb_wdata <= '0;
      eng_x    <= '0;
      eng_y    <= '0;
    end else begin
      state   <= state_n;
      px      <= px_n;
      py      <= py_n;
      x_acc   <= x_n;
      y_acc   <= y_n;
      fb_addr <= addr_n;
      tcnt    <= tcnt_n;
      if (latch) fb_wdata <= map_iter(iter_l);
      if (state_n == S_ISSUE) begin
        eng_x <= x_n;
        eng_y <= y_n;
      end
    end
  end

  assign eng_start  = (state == S_ISSUE);
  assign fb_we      = (state == S_WRITE);
  assign frame_done = (state == S_DONE);
  assign busy       = (state != S_IDLE);

endmodule
